seq_shifter: RTL
================

# seq_shifter

Multi-cycle, handshaked shift unit for the ALU datapath. It moves one bit position per clock and takes the same operand, shift-amount and op encodings as the combinational `shifter`. It accepts requests on a valid/ready input channel and returns results on a valid/ready output channel. Its result must be bit-identical to `shifter` for every request, so the shifter test bench can drive it as the request/response end of the stream.

## Interface
- `WIDTH`, 32: operand and result width in bits.
- `SHIFT_WIDTH`, 5: shift-amount width; max shift = 2^SHIFT_WIDTH − 1.
- `OPS`, 2: op field width.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  unit can accept a request.
- `in_data`  in  WIDTH  operand.
- `in_shift`  in  SHIFT_WIDTH  shift amount, unsigned.
- `in_op`  in  OPS  one of `LEFT_SHIFTA`, `LEFT_SHIFTL`, `RIGHT_SHIFTA`, `RIGHT_SHIFTL`.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer takes the result.
- `out_data`  out  WIDTH  shifted result.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`, latch data into the work register, count ← `in_shift`, op register ← `in_op`.
  - Next state is SHIFT if `in_shift`≠0, otherwise DONE.
- SHIFT:
  - Each cycle, the work register moves one position and count decrements.
  - When count reaches 1 on the current cycle, the next state is DONE.
- DONE: `out_valid`=1. On `out_ready`, return to IDLE.
- Per-step rules:
  - `LEFT_SHIFTL` and `LEFT_SHIFTA`: shift left, LSB ← 0. Both give the same result.
  - `RIGHT_SHIFTL`: shift right, MSB ← 0.
  - `RIGHT_SHIFTA`: shift right, MSB ← old MSB (sign replicate).
- `out_data` always shows the work register. Consumers must only sample it while `out_valid`=1.
- Only one request is in flight. `in_ready`=0 in SHIFT and DONE.
- Inputs are ignored outside IDLE. A request held on `in_valid` is accepted on the first IDLE cycle.
- A shift of 2^SHIFT_WIDTH − 1 is legal. For WIDTH=32, a logical shift by 31 leaves at most one significant bit.
- Reset: `rst_n` low at any time, including mid-SHIFT or in DONE, immediately forces the following. Any in-flight request is dropped.
  - state=IDLE
  - work register=0
  - count=0
  - op register=0

## Timing
- Reset values:
  - `in_ready`=1
  - `out_valid`=0
  - `out_data`=0
- Latency from the accept edge to `out_valid`=1 is `in_shift`+1 cycles. Shift 0 gives 1 cycle; shift 31 gives 32 cycles.
- `out_valid` stays high, and `out_data` stays stable, until the cycle on which `out_ready`=1.
- The handshake completes on that edge. `in_ready` rises in the following cycle.
- Back-to-back throughput is one request per `in_shift`+2 cycles when `out_ready` is held high.
- There is no combinational path from `in_*` to `out_*`. There is no combinational path from `out_ready` to `in_ready`.

## Structure
- Shared header `shifter_defs.vh`, used by both `shifter` and `seq_shifter`. It holds:
  - `WIDTH`, `SHIFT_WIDTH`, `OPS`
  - the four op defines
  - FSM state encodings (2 bits)
- Sub-module `shift_step`: combinational shift by one position. Inputs are `WIDTH` data and `OPS` op; output is `WIDTH` data.
- The top level holds the FSM, the down-counter and the registers.

## Test plan
- Reset then idle:
  - With `rst_n` low, check `in_ready`=1, `out_valid`=0, `out_data`=0.
  - Release reset; outputs are unchanged.
- Arithmetic right shift:
  - Request data 32'h8000_00F0, shift 5, op `RIGHT_SHIFTA`.
  - `out_valid` rises 6 cycles after accept with `out_data`=32'hFC00_0007.
  - With `RIGHT_SHIFTL`, the result is 32'h0400_0007.
- Left shift and zero shift:
  - Data 32'h0000_0001, shift 31, `LEFT_SHIFTL` → 32'h8000_0000 after 32 cycles.
  - Shift 0 on any op → result equals input after 1 cycle.
- Backpressure:
  - Hold `out_ready`=0 for 10 cycles after `out_valid`.
  - `out_data` is stable, `in_ready`=0, and a pending `in_valid` is not accepted.
  - Raise `out_ready`; `in_ready`=1 the next cycle.
- Mid-operation reset:
  - Assert `rst_n`=0 during SHIFT of a shift-20 request.
  - Outputs return to reset values immediately.
  - After release, a new request completes correctly.
- Random equivalence:
  - 32 random data, shift and op triples, back-to-back with `out_ready`=1.
  - Compare every result against the combinational `shifter` instance and against the `<<`, `>>` and `$signed >>>` model.
  - Zero mismatches.

Source files
------------

// File: rtl/seq_shifter_pkg.sv
// Shared widths, op encodings, FSM states and request payload for the sequential shifter.
package seq_shifter_pkg;

    localparam int unsigned WIDTH       = 32;
    localparam int unsigned SHIFT_WIDTH = 5;
    localparam int unsigned OPS         = 2;
    localparam int unsigned MAX_SHIFT   = (1 << SHIFT_WIDTH) - 1;

    typedef enum logic [OPS-1:0] {
        LEFT_SHIFTA  = 2'd0,
        LEFT_SHIFTL  = 2'd1,
        RIGHT_SHIFTA = 2'd2,
        RIGHT_SHIFTL = 2'd3
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef struct packed {
        logic [WIDTH-1:0]       data;
        logic [SHIFT_WIDTH-1:0] shift;
        shift_op_e              op;
    } shift_req_t;

endpackage

// File: rtl/shift_step.sv
// Combinational one-position shift; both left ops fill with zero, arithmetic right replicates the MSB.
module shift_step
    import seq_shifter_pkg::*;
(
    input  logic [WIDTH-1:0] data_i,
    input  shift_op_e        op_i,
    output logic [WIDTH-1:0] data_c
);

    always_comb begin
        data_c = data_i;
        case (op_i)
            LEFT_SHIFTA,
            LEFT_SHIFTL:  data_c = {data_i[WIDTH-2:0], 1'b0};
            RIGHT_SHIFTL: data_c = {1'b0, data_i[WIDTH-1:1]};
            RIGHT_SHIFTA: data_c = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
            default:      data_c = data_i;
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle handshaked shifter: one bit position per clock, one request in flight.
module seq_shifter
    import seq_shifter_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SHIFT_WIDTH-1:0] in_shift,
    input  logic [OPS-1:0]         in_op,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data
);

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       work_q, work_d;
    logic [SHIFT_WIDTH-1:0] count_q, count_d;
    shift_op_e              op_q, op_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic [WIDTH-1:0]       step_c;
    shift_req_t             req_c;

    assign req_c = '{data: in_data, shift: in_shift, op: shift_op_e'(in_op)};

    shift_step u_step (
        .data_i (work_q),
        .op_i   (op_q),
        .data_c (step_c)
    );

    // Next-state, counter and datapath update; handshake flags follow the next state.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        count_d = count_q;
        op_d    = op_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    work_d  = req_c.data;
                    count_d = req_c.shift;
                    op_d    = req_c.op;
                    state_d = (req_c.shift != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                work_d  = step_c;
                count_d = count_q - SHIFT_WIDTH'(1);
                if (count_q == SHIFT_WIDTH'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            work_q      <= '0;
            count_q     <= '0;
            op_q        <= LEFT_SHIFTA;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            count_q     <= count_d;
            op_q        <= op_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = work_q;

endmodule
